// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared types and codes for the string-instruction sequencer
package exec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } seq_state_e;

    localparam logic [1:0] REP_NONE = 2'd0;
    localparam logic [1:0] REP_E    = 2'd1;
    localparam logic [1:0] REP_NE   = 2'd2;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_WORD  = 2'd1;
    localparam logic [1:0] SZ_DWORD = 2'd2;

    // Size code 3 behaves like a dword.
    function automatic logic [31:0] step_of(input logic [1:0] size);
        case (size)
            SZ_BYTE: step_of = 32'd1;
            SZ_WORD: step_of = 32'd2;
            default: step_of = 32'd4;
        endcase
    endfunction

endpackage

// File: rtl/rep_sequencer_if.sv
// rtl/rep_sequencer_if.sv - instruction, execute and result handshakes of rep_sequencer
interface rep_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_rep;
    logic        in_is_cmps;
    logic [1:0]  in_size;
    logic        in_df;
    logic [31:0] in_ecx;
    logic [31:0] in_esi;
    logic [31:0] in_edi;
    logic [31:0] in_eip;
    logic [3:0]  in_instr_len;

    logic        exe_valid;
    logic [31:0] exe_esi;
    logic [31:0] exe_edi;
    logic        exe_done;
    logic        exe_zf;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ecx;
    logic [31:0] out_esi;
    logic [31:0] out_edi;
    logic [31:0] out_next_eip;
    logic        out_fault;

    modport slave (
        input  in_valid, in_rep, in_is_cmps, in_size, in_df,
               in_ecx, in_esi, in_edi, in_eip, in_instr_len,
        output in_ready,
        output exe_valid, exe_esi, exe_edi,
        input  exe_done, exe_zf,
        output out_valid, out_ecx, out_esi, out_edi, out_next_eip, out_fault,
        input  out_ready
    );

    modport master (
        output in_valid, in_rep, in_is_cmps, in_size, in_df,
               in_ecx, in_esi, in_edi, in_eip, in_instr_len,
        input  in_ready,
        input  exe_valid, exe_esi, exe_edi,
        output exe_done, exe_zf,
        input  out_valid, out_ecx, out_esi, out_edi, out_next_eip, out_fault,
        output out_ready
    );
endinterface

// File: rtl/str_step.sv
// rtl/str_step.sv - one-element ESI/EDI/ECX update for a string instruction
module str_step
    import exec_pkg::*;
(
    input  logic [31:0] esi,
    input  logic [31:0] edi,
    input  logic [31:0] ecx,
    input  logic [1:0]  size,
    input  logic        df,
    input  logic [1:0]  rep,
    output logic [31:0] esi_next,
    output logic [31:0] edi_next,
    output logic [31:0] ecx_next,
    output logic        ecx_zero
);
    logic [31:0] step;

    always_comb begin
        step     = step_of(size);
        esi_next = df ? (esi - step) : (esi + step);
        edi_next = df ? (edi - step) : (edi + step);
        ecx_next = (rep != REP_NONE) ? (ecx - 32'd1) : ecx;
        ecx_zero = (ecx_next == 32'd0);
    end
endmodule

// File: rtl/rep_sequencer.sv
// rtl/rep_sequencer.sv - REP/REPE/REPNE MOVS/CMPS sequencer; REP_ITER_LIMIT_EN adds an iteration cap
module rep_sequencer
    import exec_pkg::*;
#(
    parameter int MAX_ITERS = 65536
) (
    input  logic           clk,
    input  logic           rst,
    rep_sequencer_if.slave bus
);
    seq_state_e  state;
    logic        in_ready_q;
    logic        exe_valid_q;
    logic        out_valid_q;
    logic        fault_q;
    logic [1:0]  rep_q;
    logic        cmps_q;
    logic [1:0]  size_q;
    logic        df_q;
    logic [31:0] ecx_q;
    logic [31:0] esi_q;
    logic [31:0] edi_q;
    logic [31:0] eip_q;
    logic [3:0]  len_q;
    logic [31:0] next_eip_q;

    logic [31:0] esi_n;
    logic [31:0] edi_n;
    logic [31:0] ecx_n;
    logic        ecx_zero_n;
    logic        terminate;
    logic        limit_hit;

    str_step u_step (
        .esi      (esi_q),
        .edi      (edi_q),
        .ecx      (ecx_q),
        .size     (size_q),
        .df       (df_q),
        .rep      (rep_q),
        .esi_next (esi_n),
        .edi_next (edi_n),
        .ecx_next (ecx_n),
        .ecx_zero (ecx_zero_n)
    );

    // MOVS never looks at ZF; only CMPS under REPE/REPNE can stop early.
    assign terminate = (rep_q == REP_NONE) || ecx_zero_n ||
                       (cmps_q && (rep_q == REP_E)  && !bus.exe_zf) ||
                       (cmps_q && (rep_q == REP_NE) &&  bus.exe_zf);

`ifdef REP_ITER_LIMIT_EN
    logic [31:0] iter_cnt;
    logic [31:0] iter_cnt_n;

    assign iter_cnt_n = iter_cnt + 32'd1;
    assign limit_hit  = (iter_cnt_n >= 32'(MAX_ITERS));

    always_ff @(posedge clk) begin
        if (rst) begin
            iter_cnt <= 32'd0;
        end else if (state == ST_IDLE && in_ready_q && bus.in_valid) begin
            iter_cnt <= 32'd0;
        end else if (state == ST_WAIT && bus.exe_done) begin
            iter_cnt <= iter_cnt_n;
        end
    end
`else
    assign limit_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            in_ready_q  <= 1'b0;
            exe_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            fault_q     <= 1'b0;
            rep_q       <= REP_NONE;
            cmps_q      <= 1'b0;
            size_q      <= SZ_BYTE;
            df_q        <= 1'b0;
            ecx_q       <= 32'd0;
            esi_q       <= 32'd0;
            edi_q       <= 32'd0;
            eip_q       <= 32'd0;
            len_q       <= 4'd0;
            next_eip_q  <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_ready_q && bus.in_valid) begin
                        in_ready_q <= 1'b0;
                        fault_q    <= 1'b0;
                        rep_q      <= (bus.in_rep == 2'd3) ? REP_NONE : bus.in_rep;
                        cmps_q     <= bus.in_is_cmps;
                        size_q     <= bus.in_size;
                        df_q       <= bus.in_df;
                        ecx_q      <= bus.in_ecx;
                        esi_q      <= bus.in_esi;
                        edi_q      <= bus.in_edi;
                        eip_q      <= bus.in_eip;
                        len_q      <= bus.in_instr_len;
                        state      <= ST_CHECK;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (rep_q != REP_NONE && ecx_q == 32'd0) begin
                        next_eip_q  <= eip_q + {28'd0, len_q};
                        out_valid_q <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        exe_valid_q <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    exe_valid_q <= 1'b0;
                    state       <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.exe_done) begin
                        esi_q <= esi_n;
                        edi_q <= edi_n;
                        ecx_q <= ecx_n;
                        if (terminate) begin
                            next_eip_q  <= eip_q + {28'd0, len_q};
                            out_valid_q <= 1'b1;
                            state       <= ST_DONE;
                        end else if (limit_hit) begin
                            // Faulting leaves EIP on this instruction so it restarts.
                            next_eip_q  <= eip_q;
                            fault_q     <= 1'b1;
                            out_valid_q <= 1'b1;
                            state       <= ST_DONE;
                        end else begin
                            exe_valid_q <= 1'b1;
                            state       <= ST_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.exe_valid    = exe_valid_q;
    assign bus.exe_esi      = esi_q;
    assign bus.exe_edi      = edi_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_ecx      = ecx_q;
    assign bus.out_esi      = esi_q;
    assign bus.out_edi      = edi_q;
    assign bus.out_next_eip = next_eip_q;
    assign bus.out_fault    = fault_q;
endmodule

// File: tb/tb_rep_sequencer.sv
// tb/tb_rep_sequencer.sv - scoreboard bench for rep_sequencer
module tb_rep_sequencer;
    logic clk;
    logic rst;
    logic resp_done;
    logic stray_done;

    rep_sequencer_if bus ();

    rep_sequencer #(.MAX_ITERS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.exe_done = resp_done | stray_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ecx;
        logic [31:0] esi;
        logic [31:0] edi;
        logic [31:0] eip;
        logic        fault;
        int          iters;
        int          lat;
    } exp_t;

    exp_t sb[$];
    bit   zf_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   first_cyc = 0;
    bit   seen = 0;
    int   exe_pulses = 0;
    int   last_pulses = 0;
    bit   pend = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Execute stage model: answers each exe_valid during the following (WAIT) cycle.
    always @(negedge clk) begin
        resp_done = 1'b0;
        if (pend) begin
            resp_done   = 1'b1;
            bus.exe_zf  = (zf_q.size() != 0) ? zf_q.pop_front() : 1'b0;
            pend        = 1'b0;
        end
        if (bus.exe_valid) begin
            pend = 1'b1;
            exe_pulses++;
        end
    end

    // Monitor: compares each accepted result against the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            seen = 1'b0;
        end else if (bus.out_valid) begin
            if (!seen) begin
                seen      = 1'b1;
                first_cyc = cyc;
            end
            if (bus.out_ready) begin
                seen = 1'b0;
                if (sb.size() == 0) begin
                    chk("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("ecx",      bus.out_ecx,      e.ecx);
                    chk("esi",      bus.out_esi,      e.esi);
                    chk("edi",      bus.out_edi,      e.edi);
                    chk("next_eip", bus.out_next_eip, e.eip);
                    chk("fault",    {31'd0, bus.out_fault}, {31'd0, e.fault});
                    chk("iters",    32'(exe_pulses - last_pulses), 32'(e.iters));
                    chk("latency",  32'(first_cyc - acc_cyc),      32'(e.lat));
                    last_pulses = exe_pulses;
                end
            end
        end
    end

    task automatic send(input logic [1:0] rep, input logic cmps, input logic [1:0] size,
                        input logic df, input logic [31:0] ecx, input logic [31:0] esi,
                        input logic [31:0] edi, input logic [31:0] eip, input logic [3:0] len,
                        input bit zfs[$]);
        int n;
        @(negedge clk);
        bus.in_rep = rep; bus.in_is_cmps = cmps; bus.in_size = size; bus.in_df = df;
        bus.in_ecx = ecx; bus.in_esi = esi; bus.in_edi = edi; bus.in_eip = eip;
        bus.in_instr_len = len;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        acc_cyc = cyc;
        #1;
        bus.in_valid = 1'b0;
        foreach (zfs[i]) zf_q.push_back(zfs[i]);
    endtask

    task automatic run(input logic [1:0] rep, input logic cmps, input logic [1:0] size,
                       input logic df, input logic [31:0] ecx, input logic [31:0] esi,
                       input logic [31:0] edi, input logic [31:0] eip, input logic [3:0] len,
                       input bit zfs[$], input logic [31:0] x_ecx, input logic [31:0] x_esi,
                       input logic [31:0] x_edi, input logic [31:0] x_eip, input logic x_fault,
                       input int x_iters);
        exp_t e;
        e.ecx = x_ecx; e.esi = x_esi; e.edi = x_edi; e.eip = x_eip;
        e.fault = x_fault; e.iters = x_iters; e.lat = 2 + 2 * x_iters;
        sb.push_back(e);
        send(rep, cmps, size, df, ecx, esi, edi, eip, len, zfs);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        bit none[$];
        bit z[$];
        int n;
        rst = 1'b1; stray_done = 1'b0; resp_done = 1'b0;
        bus.in_valid = 1'b0; bus.in_rep = 2'd0; bus.in_is_cmps = 1'b0; bus.in_size = 2'd0;
        bus.in_df = 1'b0; bus.in_ecx = '0; bus.in_esi = '0; bus.in_edi = '0; bus.in_eip = '0;
        bus.in_instr_len = '0; bus.exe_zf = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
        chk("rst_exe_valid", {31'd0, bus.exe_valid}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_fault", {31'd0, bus.out_fault}, 32'd0);
        chk("rst_out_esi",   bus.out_esi,      32'd0);
        chk("rst_next_eip",  bus.out_next_eip, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", {31'd0, bus.in_ready}, 32'd1);

        run(2'd0, 1'b0, 2'd2, 1'b0, 32'd5, 32'h1000, 32'h2000, 32'h400, 4'd1, none,
            32'd5, 32'h1004, 32'h2004, 32'h401, 1'b0, 1);
        run(2'd1, 1'b0, 2'd0, 1'b1, 32'd3, 32'h1, 32'h10, 32'h500, 4'd2, none,
            32'd0, 32'hFFFF_FFFE, 32'hD, 32'h502, 1'b0, 3);
        run(2'd1, 1'b0, 2'd1, 1'b0, 32'd0, 32'h40, 32'h80, 32'h510, 4'd2, none,
            32'd0, 32'h40, 32'h80, 32'h512, 1'b0, 0);

        // REPE CMPS with the result held off for a few cycles.
        drain();
        bus.out_ready = 1'b0;
        z = '{1'b1, 1'b1, 1'b0};
        run(2'd1, 1'b1, 2'd1, 1'b0, 32'd10, 32'h100, 32'h200, 32'h600, 4'd3, z,
            32'd7, 32'h106, 32'h206, 32'h603, 1'b0, 3);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("hold_ecx",   bus.out_ecx,            32'd7);
        chk("hold_esi",   bus.out_esi,            32'h106);
        bus.out_ready = 1'b1;

        z = '{1'b0, 1'b1};
        run(2'd2, 1'b1, 2'd2, 1'b0, 32'd4, 32'h3000, 32'h4000, 32'h610, 4'd2, z,
            32'd2, 32'h3008, 32'h4008, 32'h612, 1'b0, 2);
        z = '{1'b0, 1'b0};
        run(2'd2, 1'b1, 2'd0, 1'b1, 32'd2, 32'h10, 32'h20, 32'h620, 4'd1, z,
            32'd0, 32'hE, 32'h1E, 32'h621, 1'b0, 2);
        run(2'd3, 1'b0, 2'd3, 1'b1, 32'd7, 32'h0, 32'h8, 32'hFFFF_FFFF, 4'd2, none,
            32'd7, 32'hFFFF_FFFC, 32'h4, 32'h1, 1'b0, 1);
        z = '{1'b0, 1'b0};
        run(2'd1, 1'b0, 2'd0, 1'b0, 32'd2, 32'h0, 32'h0, 32'h800, 4'd15, z,
            32'd0, 32'h2, 32'h2, 32'h80F, 1'b0, 2);
        drain();

        // Reset during the WAIT of the second iteration.
        send(2'd1, 1'b0, 2'd2, 1'b0, 32'd5, 32'h100, 32'h200, 32'h700, 4'd1, none);
        n = 0;
        while ((exe_pulses - last_pulses) < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_exe_valid", {31'd0, bus.exe_valid}, 32'd0);
        chk("midrst_ecx",       bus.out_ecx,            32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        chk("stray_done_ignored", {29'd0, dut.state}, 32'd0);
        repeat (4) @(negedge clk);
        chk("midrst_no_out", {31'd0, bus.out_valid}, 32'd0);
        zf_q.delete();
        last_pulses = exe_pulses;

        run(2'd0, 1'b0, 2'd0, 1'b0, 32'd9, 32'hFFFF_FFFF, 32'h5, 32'h900, 4'd4, none,
            32'd9, 32'h0, 32'h6, 32'h904, 1'b0, 1);
`ifdef REP_ITER_LIMIT_EN
        run(2'd1, 1'b0, 2'd2, 1'b0, 32'd100, 32'h100, 32'h200, 32'h700, 4'd2, none,
            32'd96, 32'h110, 32'h210, 32'h700, 1'b1, 4);
`else
        run(2'd1, 1'b0, 2'd2, 1'b0, 32'd6, 32'h100, 32'h200, 32'h700, 4'd2, none,
            32'd0, 32'h118, 32'h218, 32'h702, 1'b0, 6);
`endif
        drain();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rep_sequencer.md
# rep_sequencer

Multi-cycle controller that runs x86 string instructions (MOVS, CMPS) through the combinational `execute` stage. It accepts one decoded string instruction and issues one `execute` iteration per element. Between iterations it updates ECX/ESI/EDI per REP/REPE/REPNE semantics and EFLAGS.DF, then returns final register state and the next EIP. It sits between decode/fetch and `execute`, and holds the step until the whole instruction has retired.

## Interface
Parameters:
- `MAX_ITERS`, default 65536: iteration cap, used only when `REP_ITER_LIMIT_EN` is defined.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  instruction offered.
- `in_ready`  out  1  sequencer can accept; high only in IDLE and not in reset.
- `in_rep`  in  2  0 = none, 1 = REP/REPE, 2 = REPNE, 3 treated as 0.
- `in_is_cmps`  in  1  instruction is CMPS (ZF-terminated); else MOVS.
- `in_size`  in  2  element size: 0 = byte, 1 = word, 2 = dword, 3 treated as dword.
- `in_df`  in  1  EFLAGS.DF at issue.
- `in_ecx`, `in_esi`, `in_edi`, `in_eip`  in  32 each  architectural state at issue.
- `in_instr_len`  in  4  instruction length.
- `exe_valid`  out  1  one-cycle pulse: run one iteration with `exe_esi`/`exe_edi`.
- `exe_esi`, `exe_edi`  out  32  current element addresses.
- `exe_done`  in  1  iteration result available; sampled only in WAIT.
- `exe_zf`  in  1  ZF produced by the iteration; valid with `exe_done`.
- `out_valid`  out  1  final state valid; held until accepted.
- `out_ready`  in  1  consumer accepts.
- `out_ecx`, `out_esi`, `out_edi`, `out_next_eip`  out  32 each  final state.
- `out_fault`  out  1  iteration cap hit. Tied 0 without `REP_ITER_LIMIT_EN`.

## Operation
States are IDLE, CHECK, ISSUE, WAIT, DONE.
- **IDLE:** `in_ready`=1. On `in_valid` it latches all `in_*` inputs and moves to CHECK.
- **CHECK:**
  - If rep≠0 and ECX==0, go to DONE with no iteration; registers are unchanged.
  - Otherwise go to ISSUE.
- **ISSUE:** `exe_valid`=1 for exactly one cycle, then go to WAIT.
- **WAIT:** Waits for `exe_done`; there is no timeout. On `exe_done`:
  - ESI and EDI each move by `step` = 1 << min(size, 2): add if DF=0, subtract if DF=1, modulo 2^32.
  - If rep≠0, ECX decrements by 1, modulo 2^32.
  - The instruction terminates on any of: rep==0; new ECX==0; CMPS with REPE and `exe_zf`=0; CMPS with REPNE and `exe_zf`=1.
  - MOVS ignores `exe_zf`.
  - On termination go to DONE; otherwise go to ISSUE.
- **DONE:**
  - `out_valid`=1 and `out_next_eip` = EIP + zero-extended instr_len, modulo 2^32.
  - Go to IDLE when `out_ready`=1. Outputs hold stable while `out_ready`=0.
- **Flags:** the flag outputs of `execute` are consumed downstream; the sequencer does not track EFLAGS beyond the latched DF.

## Timing
- **Reset:**
  - State returns to IDLE.
  - `in_ready`, `exe_valid`, `out_valid` and `out_fault` are 0.
  - All 32-bit outputs are 0.
  - `in_ready` rises the cycle after `rst` falls.
- **Reset mid-operation:** aborts immediately. No `out_valid` is produced, and a pending `exe_done` is discarded.
- **Latency:**
  - Accept to CHECK: 1 cycle.
  - CHECK with ECX==0 under rep: DONE on the next cycle, so `out_valid` appears 2 cycles after accept.
  - Each iteration: 1 ISSUE cycle plus the WAIT cycles up to and including `exe_done`.
  - With `exe_done` returned the cycle after `exe_valid`, N iterations take 2 + 2N cycles from accept to `out_valid`.
- **Simultaneous events:**
  - `exe_done` in any state other than WAIT is ignored.
  - `in_valid` outside IDLE is not accepted.
  - In DONE, `out_ready` and a new `in_valid` in the same cycle: the move to IDLE takes effect, and the new instruction is accepted on the following cycle.
- **Wrap-around:** ESI/EDI wrap 0 ↔ 0xFFFFFFFF. With rep≠0, ECX never wraps because CHECK gates ECX==0.

## Configuration
- `REP_ITER_LIMIT_EN` defined:
  - An iteration counter is cleared at accept and increments on each `exe_done`.
  - When it reaches `MAX_ITERS` without normal termination, go to DONE with `out_fault`=1.
  - On fault, `out_next_eip` = latched EIP, so the instruction restarts. ECX/ESI/EDI reflect progress so far.
- Undefined: no counter; `out_fault` constant 0.

## Structure
- **Package `exec_pkg`:** state enum, rep codes (`REP_NONE`, `REP_E`, `REP_NE`) and size codes.
- **Sub-module `str_step`** (combinational): from (esi, edi, ecx, size, df, rep) produces next esi/edi/ecx, plus the new-ECX-zero flag.
- The FSM and termination logic stay in `rep_sequencer`.

## Test plan
- **Plain MOVS dword:** rep=0, DF=0, ESI=0x1000, EDI=0x2000, ECX=5, eip=0x400, len=1 → one `exe_valid`; out ESI=0x1004, EDI=0x2004, ECX=5, next_eip=0x401.
- **REP MOVS byte, DF=1, ECX=3, ESI=0x1, EDI=0x10** → 3 pulses; out ESI=0xFFFFFFFE, EDI=0xD, ECX=0.
- **REP with ECX=0** → no `exe_valid`; `out_valid` 2 cycles after accept; registers unchanged.
- **REPE CMPS word, ECX=10; `exe_zf`=1,1,0** → 3 iterations; ECX=7, ESI/EDI advanced by 6.
- **`rst` asserted during WAIT of iteration 2** → next cycle: IDLE, `in_ready`=1, no `out_valid`; a late `exe_done` is ignored.
- **With `REP_ITER_LIMIT_EN`, `MAX_ITERS`=4, REP MOVS ECX=100** → 4 iterations; `out_fault`=1, ECX=96, next_eip = original EIP.
